clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Measures an incoming slow clock, or any periodic square wave, against org_clk.
- Reports period and high time in org_clk cycles, with a 1-cycle valid strobe, a lock flag and a timeout flag.
- This is the measuring counterpart to our divided-clock generators: it checks that a divided clock really runs at the intended ratio, and it gives system logic the ratio of a foreign clock.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- TIMEOUT, 16'hFFFF, org_clk cycles without a synchronized rising edge before timeout; must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W−1.
- LOCK_COUNT, 4, consecutive matching periods needed to assert locked (≥1).
- TOL, 1, allowed |period − previous period| still counted as a match.

Ports:
- org_clk, input, 1, measurement clock.
- sys_rst_n, input, 1, reset.
- meas_clk, input, 1, signal under measurement, asynchronous to org_clk.
- meas_en, input, 1, measurement enable.
- period, output, CNT_W, last measured period in org_clk cycles.
- high_time, output, CNT_W, high time belonging to that period.
- period_valid, output, 1, 1-cycle strobe when period/high_time update.
- locked, output, 1, period stable for LOCK_COUNT periods.
- timeout_err, output, 1, no edge within TIMEOUT cycles.

Interface: reset sys_rst_n, asynchronous, active-low; clock org_clk. All outputs are registered.

Behaviour:
- Reset: period=0, high_time=0, period_valid=0, locked=0, timeout_err=0, state=IDLE, cnt=0, match count=0, synchronizer flops=0.
- Synchronizer: 2 flops on meas_clk produce meas_s; a delay flop produces meas_d. rise = meas_s & ~meas_d; fall = ~meas_s & meas_d. rise asserts 3 org_clk edges after a setup-clean meas_clk rising edge.
- States:
  - IDLE: when meas_en=1, go to ARM; cnt=0.
  - ARM: wait for rise. On rise: cnt<=1, go to MEASURE, no output update. cnt also runs in ARM; if it reaches TIMEOUT: timeout_err<=1, cnt<=0, stay in ARM.
  - MEASURE:
    - Every cycle cnt<=cnt+1, saturating at 2^CNT_W−1.
    - On fall: hi_cap<=cnt.
    - On rise: period<=cnt, high_time<=hi_cap, period_valid<=1 next cycle only, timeout_err<=0, cnt<=1.
    - A period of N cycles between rises reports exactly N. A square wave from a divide-by-32 gives period=32, high_time=16.
- Lock (evaluated on each rise in MEASURE except the first captured period):
  - If |cnt−period| ≤ TOL: match count increments, saturating at LOCK_COUNT.
  - Otherwise: match count=0 and locked<=0 in the same cycle as the strobe.
  - locked<=1 when match count reaches LOCK_COUNT.
- Timeout in MEASURE: when cnt==TIMEOUT and no rise that cycle: timeout_err<=1, locked<=0, match count=0, cnt<=0, go to ARM. If rise and timeout coincide, rise wins.
- No fall within a period (duty 100%/0% glitch): high_time reports the stale hi_cap; hi_cap clears to 0 on each rise.
- meas_en=0 in any state: go to IDLE next cycle; locked<=0; period_valid<=0; period/high_time/timeout_err hold. Re-enable restarts from ARM, and the first period after ARM is never strobed.
- Reset mid-measurement: immediate asynchronous return to the reset values above.
- Edges faster than 3 org_clk cycles are not guaranteed to be resolved; no error is flagged.

Optional Feature:
- PERIOD_AVG_EN defined:
  - period reports the rounded mean of the last 4 captured periods: (sum+2)>>2, with a CNT_W+2 accumulator.
  - Until 4 periods are captured after ARM, period reports the raw value.
  - Lock compares raw periods.
  - high_time stays raw.
- Not defined: period is the raw last period; no accumulator logic.

Decomposition:
- Package clock_period_meter_pkg:
  - state enum {IDLE, ARM, MEASURE}.
  - SYNC_STAGES=2 constant.
  - AVG_DEPTH=4 constant.
- Sub-module edge_sync: 2-flop synchronizer plus delay flop, outputs meas_s/rise/fall, with its own async active-low reset.

Test Plan:
- meas_en=1, meas_clk from divide-by-32 of org_clk -> first strobe reports period=32, high_time=16; locked=1 on the 4th matching strobe.
- Period 20 for 6 periods, then switch to 24 -> strobe with period=24, locked drops same cycle, re-locks after 4 strobes of 24.
- meas_clk held low, TIMEOUT=100 -> timeout_err=1 about 100 cycles after the last rise, locked=0; the next two edges clear timeout_err on the first strobe.
- Deassert meas_en mid-period -> IDLE, locked=0, period holds; re-enable -> first rise gives no strobe, the next gives the correct period.
- sys_rst_n pulsed low mid-MEASURE -> all outputs 0 immediately; the following periods measure correctly.
- PERIOD_AVG_EN, periods 30, 34, 30, 34 -> 4th strobe reports period=32; strobes 1–3 report raw values.

Source files
------------

// File: rtl/clock_period_meter_pkg.sv
`default_nettype none
// =============================================================================
// clock_period_meter_pkg: shared FSM states and constants for clock_period_meter
// Rev 1.0
// =============================================================================
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int AVG_DEPTH   = 4;

endpackage
`default_nettype wire

// File: rtl/clock_period_meter_edge_sync.sv
`default_nettype none
// =============================================================================
// edge_sync: brings meas_clk into org_clk domain and flags its edges
// Rev 1.0
// =============================================================================
module edge_sync
  import clock_period_meter_pkg::*;
(
  input  logic org_clk,
  input  logic sys_rst_n,
  input  logic meas_clk,
  output logic meas_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   meas_d;

  always_ff @(posedge org_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      meas_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk};
      meas_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign meas_s = sync_q[SYNC_STAGES-1];
  assign rise   = meas_s & ~meas_d;
  assign fall   = ~meas_s & meas_d;

endmodule
`default_nettype wire

// File: rtl/clock_period_meter.sv
`default_nettype none
// =============================================================================
// clock_period_meter: period / high-time / lock / timeout of a slow clock in
// org_clk cycles. Define PERIOD_AVG_EN for a 4-period rounded mean. Rev 1.0
// =============================================================================
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int          CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 16'hFFFF,
  parameter int          LOCK_COUNT = 4,
  parameter int          TOL        = 1
) (
  input  logic             org_clk,
  input  logic             sys_rst_n,
  input  logic             meas_clk,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout_err
);

  localparam int               MW       = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_VAL  = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);

  state_t           state, state_nxt;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_inc, hi_cap, prev_raw, period_nxt, diff;
  logic [MW-1:0]    match_cnt, match_inc;
  logic             have_prev, cnt_at_to, in_tol, capture;

  edge_sync u_edge_sync (
    .org_clk   (org_clk),
    .sys_rst_n (sys_rst_n),
    .meas_clk  (meas_clk),
    .meas_s    (),
    .rise      (rise),
    .fall      (fall)
  );

  assign cnt_at_to = (cnt == TO_VAL);
  assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign diff      = (cnt >= prev_raw) ? cnt - prev_raw : prev_raw - cnt;
  assign in_tol    = (diff <= TOL_VAL);
  assign match_inc = (match_cnt == LOCK_VAL) ? match_cnt : match_cnt + 1'b1;
  assign capture   = meas_en && (state == MEASURE) && rise;

  always_ff @(posedge org_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (meas_en) state_nxt = ARM;
      ARM:     if (!meas_en) state_nxt = IDLE;
               else if (rise) state_nxt = MEASURE;
      MEASURE: if (!meas_en) state_nxt = IDLE;
               else if (!rise && cnt_at_to) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PERIOD_AVG_EN
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);
  localparam int CAP_W     = $clog2(AVG_DEPTH + 1);

  logic [CNT_W-1:0] hist [AVG_DEPTH-1];
  logic [CAP_W-1:0] cap_n;
  logic [CNT_W+1:0] sum, sum_rnd;

  always_comb begin
    sum = {2'b00, cnt};
    for (int i = 0; i < AVG_DEPTH - 1; i++) sum = sum + {2'b00, hist[i]};
    sum_rnd = sum + (CNT_W + 2)'(AVG_DEPTH / 2);
  end

  // hist[0] is the newest raw period; the lock check must never see averages.
  assign prev_raw   = hist[0];
  assign period_nxt = (cap_n >= CAP_W'(AVG_DEPTH - 1)) ? CNT_W'(sum_rnd >> AVG_SHIFT) : cnt;

  always_ff @(posedge org_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_n <= '0;
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist[i] <= '0;
    end else if (!meas_en || state != MEASURE) begin
      cap_n <= '0;
    end else if (capture) begin
      hist[0] <= cnt;
      for (int i = 1; i < AVG_DEPTH - 1; i++) hist[i] <= hist[i-1];
      if (cap_n != CAP_W'(AVG_DEPTH)) cap_n <= cap_n + 1'b1;
    end
  end
`else
  assign prev_raw   = period;
  assign period_nxt = cnt;
`endif

  always_ff @(posedge org_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout_err  <= 1'b0;
      cnt          <= '0;
      hi_cap       <= '0;
      match_cnt    <= '0;
      have_prev    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!meas_en) begin
        locked    <= 1'b0;
        cnt       <= '0;
        match_cnt <= '0;
        have_prev <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt       <= '0;
            match_cnt <= '0;
            have_prev <= 1'b0;
          end
          ARM: begin
            if (rise) begin
              cnt    <= CNT_W'(1);
              hi_cap <= '0;
            end else if (cnt_at_to) begin
              timeout_err <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          MEASURE: begin
            if (capture) begin
              period       <= period_nxt;
              high_time    <= hi_cap;
              period_valid <= 1'b1;
              timeout_err  <= 1'b0;
              cnt          <= CNT_W'(1);
              hi_cap       <= '0;
              have_prev    <= 1'b1;
              // The first period after ARM has no predecessor to compare with.
              if (have_prev) begin
                if (in_tol) begin
                  match_cnt <= match_inc;
                  if (match_inc == LOCK_VAL) locked <= 1'b1;
                end else begin
                  match_cnt <= '0;
                  locked    <= 1'b0;
                end
              end
            end else if (cnt_at_to) begin
              timeout_err <= 1'b1;
              locked      <= 1'b0;
              match_cnt   <= '0;
              cnt         <= '0;
              have_prev   <= 1'b0;
            end else begin
              cnt <= cnt_inc;
              if (fall) hi_cap <= cnt;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// =============================================================================
// tb_clock_period_meter: directed self-checking bench for clock_period_meter
// Rev 1.0
// =============================================================================
module tb_clock_period_meter;

`ifdef PERIOD_AVG_EN
  localparam int EXP_SWITCH = 21;  // (20+20+20+24+2)>>2
  localparam int EXP_AVG4   = 32;  // (30+34+30+34+2)>>2
`else
  localparam int EXP_SWITCH = 24;
  localparam int EXP_AVG4   = 34;
`endif

  logic        org_clk = 1'b0;
  logic        sys_rst_n;
  logic        meas_clk;
  logic        meas_en;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        period_valid;
  logic        locked;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  int          n_strobe = 0;
  logic [15:0] s_period;
  logic [15:0] s_high;
  logic        s_locked;
  logic        s_terr;
  int          base;

  clock_period_meter #(
    .CNT_W      (16),
    .TIMEOUT    (100),
    .LOCK_COUNT (4),
    .TOL        (1)
  ) dut (
    .org_clk      (org_clk),
    .sys_rst_n    (sys_rst_n),
    .meas_clk     (meas_clk),
    .meas_en      (meas_en),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout_err  (timeout_err)
  );

  always #5 org_clk = ~org_clk;

  // Snapshot every strobe so the stimulus sequence can inspect the latest one.
  always @(negedge org_clk) begin
    if (period_valid === 1'b1) begin
      n_strobe = n_strobe + 1;
      s_period = period;
      s_high   = high_time;
      s_locked = locked;
      s_terr   = timeout_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int hi, input int lo);
    meas_clk = 1'b1;
    repeat (hi) @(negedge org_clk);
    meas_clk = 1'b0;
    repeat (lo) @(negedge org_clk);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    meas_en   = 1'b0;
    meas_clk  = 1'b0;
    repeat (2) @(negedge org_clk);
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", 32'(period_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_terr", 32'(timeout_err), 0);
    sys_rst_n = 1'b1;
    @(negedge org_clk);
    meas_en = 1'b1;
    repeat (3) @(negedge org_clk);

    // divide-by-32 square wave
    cyc(16, 16);
    check("div32_arm_nostrobe", 32'(n_strobe), 0);
    cyc(16, 16);
    check("div32_strobe_cnt", 32'(n_strobe), 1);
    check("div32_period", 32'(s_period), 32);
    check("div32_high", 32'(s_high), 16);
    check("div32_unlocked1", 32'(s_locked), 0);
    repeat (3) cyc(16, 16);
    check("div32_unlocked4", 32'(s_locked), 0);
    cyc(16, 16);
    check("div32_locked", 32'(s_locked), 1);

    // period 20, then switch to 24
    repeat (6) cyc(10, 10);
    check("p20_period", 32'(s_period), 20);
    check("p20_high", 32'(s_high), 10);
    check("p20_locked", 32'(s_locked), 1);
    cyc(12, 12);
    check("p20_last_locked", 32'(s_locked), 1);
    cyc(12, 12);
    check("p24_switch_period", 32'(s_period), EXP_SWITCH);
    check("p24_switch_high", 32'(s_high), 12);
    check("p24_switch_unlock", 32'(s_locked), 0);
    repeat (3) cyc(12, 12);
    check("p24_unlocked3", 32'(s_locked), 0);
    cyc(12, 12);
    check("p24_relock", 32'(s_locked), 1);

    // a 25-cycle period is within tolerance of 24
    cyc(13, 12);
    cyc(12, 12);
    check("tol_high", 32'(s_high), 13);
    check("tol_locked", 32'(s_locked), 1);

    // last rise, then meas_clk held low until timeout
    meas_clk = 1'b1;
    repeat (12) @(negedge org_clk);
    meas_clk = 1'b0;
    repeat (90) @(negedge org_clk);
    check("to_not_yet", 32'(timeout_err), 0);
    check("to_locked_before", 32'(locked), 1);
    @(negedge org_clk);
    check("to_err", 32'(timeout_err), 1);
    check("to_locked", 32'(locked), 0);
    check("to_period_hold", 32'(period), 24);
    base = n_strobe;
    cyc(12, 12);
    check("to_arm_nostrobe", 32'(n_strobe), 32'(base));
    check("to_err_held", 32'(timeout_err), 1);
    cyc(12, 12);
    check("to_recover_strobe", 32'(n_strobe), 32'(base + 1));
    check("to_recover_terr", 32'(s_terr), 0);
    check("to_recover_period", 32'(s_period), 24);

    // disable mid-period, then re-enable
    repeat (4) cyc(12, 12);
    check("en_locked_before", 32'(s_locked), 1);
    meas_clk = 1'b1;
    repeat (6) @(negedge org_clk);
    meas_en = 1'b0;
    repeat (2) @(negedge org_clk);
    check("dis_locked", 32'(locked), 0);
    check("dis_period_hold", 32'(period), 24);
    check("dis_high_hold", 32'(high_time), 12);
    check("dis_valid", 32'(period_valid), 0);
    meas_clk = 1'b0;
    repeat (4) @(negedge org_clk);
    meas_en = 1'b1;
    repeat (3) @(negedge org_clk);
    base = n_strobe;
    cyc(8, 8);
    check("reen_nostrobe", 32'(n_strobe), 32'(base));
    cyc(8, 8);
    check("reen_strobe", 32'(n_strobe), 32'(base + 1));
    check("reen_period", 32'(s_period), 16);
    check("reen_high", 32'(s_high), 8);

    // asynchronous reset in the middle of a measurement
    cyc(8, 8);
    meas_clk = 1'b1;
    repeat (4) @(negedge org_clk);
    meas_clk = 1'b0;
    repeat (3) @(negedge org_clk);
    check("pre_rst_period", 32'(period), 16);
    sys_rst_n = 1'b0;
    #1;
    check("arst_period", 32'(period), 0);
    check("arst_high", 32'(high_time), 0);
    check("arst_valid", 32'(period_valid), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_terr", 32'(timeout_err), 0);
    repeat (2) @(negedge org_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge org_clk);
    base = n_strobe;
    cyc(10, 10);
    check("post_rst_nostrobe", 32'(n_strobe), 32'(base));
    cyc(10, 10);
    check("post_rst_period", 32'(s_period), 20);
    check("post_rst_high", 32'(s_high), 10);

    // alternating 30/34 periods (averaged when PERIOD_AVG_EN is defined)
    meas_en = 1'b0;
    repeat (2) @(negedge org_clk);
    meas_en = 1'b1;
    repeat (3) @(negedge org_clk);
    base = n_strobe;
    cyc(15, 15);
    cyc(17, 17);
    check("avg_s1_period", 32'(s_period), 30);
    cyc(15, 15);
    check("avg_s2_period", 32'(s_period), 34);
    cyc(17, 17);
    check("avg_s3_period", 32'(s_period), 30);
    cyc(15, 15);
    check("avg_s4_period", 32'(s_period), EXP_AVG4);
    check("avg_s4_high", 32'(s_high), 17);
    check("avg_strobes", 32'(n_strobe), 32'(base + 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
